// File: rtl/ic74157_mux_core.sv
// ic74157_mux_core: quad 2:1 mux with output enable, registered copy and optional select/disable statistics (IC74157_STATS_EN)
module ic74157_mux_core #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             noe,
  input  logic             s,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  output logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] z_q,
  output logic [CNT_W-1:0] sel_changes,
  output logic [CNT_W-1:0] dis_cycles
);
  // noe wins over an unknown select, so a disabled output is always clean zero
  assign z = noe ? '0 : (s ? i1 : i0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) z_q <= '0;
    else z_q <= z;
`ifdef IC74157_STATS_EN
  logic             s_d;
  logic [CNT_W-1:0] sel_changes_q, sel_changes_d;
  logic [CNT_W-1:0] dis_cycles_q, dis_cycles_d;
  always_comb begin
    sel_changes_d = (!noe && s != s_d && !(&sel_changes_q)) ? sel_changes_q + 1'b1 : sel_changes_q;
    dis_cycles_d  = (noe && !(&dis_cycles_q)) ? dis_cycles_q + 1'b1 : dis_cycles_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s_d           <= 1'b0;
      sel_changes_q <= '0;
      dis_cycles_q  <= '0;
    end else begin
      s_d           <= s;
      sel_changes_q <= sel_changes_d;
      dis_cycles_q  <= dis_cycles_d;
    end
  assign sel_changes = sel_changes_q;
  assign dis_cycles  = dis_cycles_q;
`else
  assign sel_changes = '0;
  assign dis_cycles  = '0;
`endif
endmodule

// File: tb/tb_ic74157_mux_core.sv
// tb_ic74157_mux_core: scoreboard bench for the mux, its registered copy and the statistics counters
module tb_ic74157_mux_core;
  logic       clk = 1'b0, rst_n = 1'b0, noe = 1'b0, s = 1'b0;
  logic [3:0] i0 = 4'h0, i1 = 4'h0, z, z_q;
  logic [7:0] sel_changes, dis_cycles;
  logic [3:0] zq_sb[$];
  logic [7:0] sel_m = 8'h0, dis_m = 8'h0;
  logic       s_m = 1'b0;
  int checks = 0, failures = 0;
  ic74157_mux_core #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .noe(noe), .s(s), .i0(i0), .i1(i1),
    .z(z), .z_q(z_q), .sel_changes(sel_changes), .dis_cycles(dis_cycles)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask
  task automatic step(input logic n, input logic sv, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] e;
    noe = n; s = sv; i0 = a; i1 = b;
    #1;
    e = n ? 4'h0 : (sv ? b : a);
    chk("z", z, e);
    zq_sb.push_back(e);
`ifdef IC74157_STATS_EN
    if (!n && sv != s_m && sel_m != 8'hff) sel_m++;
    if (n && dis_m != 8'hff) dis_m++;
    s_m = sv;
`endif
    @(posedge clk);
    #1;
    if (zq_sb.size() == 0) chk("sb_empty", 1, 0);
    else chk("z_q", z_q, zq_sb.pop_front());
    chk("sel_changes", sel_changes, sel_m);
    chk("dis_cycles", dis_cycles, dis_m);
  endtask
  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_z_q", z_q, 0);
    chk("rst_sel", sel_changes, 0);
    chk("rst_dis", dis_cycles, 0);
    chk("rst_z_comb", z, noe ? 4'h0 : (s ? i1 : i0));
    zq_sb.delete();
    sel_m = 8'h0; dis_m = 8'h0; s_m = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask
  initial begin
    noe = 1'b0; s = 1'b1; i0 = 4'h5; i1 = 4'hA;
    #1;
    chk("rst0_z_q", z_q, 0);
    chk("rst0_sel", sel_changes, 0);
    chk("rst0_dis", dis_cycles, 0);
    chk("rst0_z_comb", z, 4'hA);
    #2 rst_n = 1'b1;
    step(1'b0, 1'b0, 4'h5, 4'hA);
    step(1'b0, 1'b1, 4'h5, 4'hA);
    step(1'b1, 1'b0, 4'h5, 4'hA);
    step(1'b1, 1'b1, 4'h5, 4'hA);
    step(1'b1, 1'b0, 4'hF, 4'hF);
    step(1'b0, 1'b0, 4'h3, 4'hC);
    pulse_reset();
    for (int k = 0; k < 10; k++) step(1'b0, (k % 2) == 0, 4'h5, 4'hA);
`ifdef IC74157_STATS_EN
    chk("sel_ten", sel_changes, 10);
`else
    chk("sel_ten_off", sel_changes, 0);
`endif
    for (int k = 0; k < 40; k++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom));
    pulse_reset();
    for (int k = 0; k < 260; k++) step(1'b0, (k % 2) == 0, 4'($urandom), 4'($urandom));
    for (int k = 0; k < 300; k++) step(1'b1, (k % 3) == 0, 4'($urandom), 4'($urandom));
`ifdef IC74157_STATS_EN
    chk("sel_sat", sel_changes, 255);
    chk("dis_sat", dis_cycles, 255);
`endif
    step(1'b0, 1'b1, 4'h6, 4'h9);
    pulse_reset();
    step(1'b0, 1'b1, 4'h1, 4'h2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
